arp_sequencer: RTL and testbench
================================

ARP_SEQUENCER -- requirements
Module: arp_sequencer

Interface
REQ-001 SHALL have parameter MAX_NOTES, default 8: chord table depth, a power of two of at least 2.
REQ-002 SHALL have parameter PHASE_WIDTH, default 32: width of DDS phase increment.
REQ-003 SHALL have parameter DUR_WIDTH, default 16: width of duration counters, counted in samples.
REQ-004 SHALL define localparam IDX_W = clog2(MAX_NOTES).
REQ-005 SHALL have one clock and a synchronous, active-low reset; ports clk and rst_n.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 sample_tick  input  1  one-cycle strobe, once per audio sample.
REQ-009 enable  input  1  run request.
REQ-010 pattern  input  2  0 UP, 1 DOWN, 2 UPDOWN, 3 RANDOM.
REQ-011 num_notes  input  IDX_W+1  number of active chord entries, 0..MAX_NOTES.
REQ-012 note_dur  input  DUR_WIDTH  samples per step; 0 is treated as 1.
REQ-013 gate_len  input  DUR_WIDTH  sounding samples per step; the remainder of the step is rest.
REQ-014 wr_en / wr_addr[IDX_W-1:0] / wr_delta[PHASE_WIDTH-1:0]  input  chord-table write port.
REQ-015 delta_out  output  PHASE_WIDTH  DDS phase increment; 0 means rest.
REQ-016 note_idx  output  IDX_W  current chord index.
REQ-017 gate  output  1  high while the note sounds.
REQ-018 step_strobe  output  1  one-cycle pulse on each step start.

Function
REQ-019 SHALL hold a MAX_NOTES x PHASE_WIDTH register table; wr_en writes wr_delta at wr_addr on the next edge.
REQ-020 SHALL implement FSM IDLE/PLAY: IDLE->PLAY when enable=1 and num_notes!=0; PLAY->IDLE when enable=0 or num_notes=0, checked every cycle.
REQ-021 SHALL drive delta_out=0, gate=0 and step_strobe=0 in IDLE.
REQ-022 On the IDLE->PLAY edge, SHALL start step 0 with 1-cycle latency: note_idx = pattern start (UP 0; DOWN num_notes-1; UPDOWN 0 ascending; RANDOM lfsr value), sample counter = 0, step_strobe pulses.
REQ-023 SHALL increment the sample counter only on sample_tick.
REQ-024 When sample_tick arrives with counter = max(note_dur,1)-1, SHALL reset the counter to 0, advance note_idx, and pulse step_strobe on the next cycle.
REQ-025 UP: idx+1, wrapping at num_notes-1 to 0; DOWN: idx-1, wrapping at 0 to num_notes-1.
REQ-026 UPDOWN: bounce without repeating endpoints (0,1,2,1,0,1 for 3 notes); num_notes=1 yields 0 repeatedly.
REQ-027 RANDOM: idx = lfsr[7:0] mod num_notes; the LFSR advances once per step.
REQ-028 If note_idx >= num_notes at a step (num_notes reduced), SHALL restart at the pattern start.
REQ-029 A pattern change SHALL take effect at the next step boundary; UPDOWN direction resets to ascending.
REQ-030 gate SHALL be 1 while counter < gate_len; gate_len >= note_dur gives legato; gate_len=0 gives full rest.
REQ-031 delta_out SHALL equal gate ? table[note_idx] : 0, registered; table writes to the playing index appear on the next cycle.
REQ-032 A sample_tick in the same cycle as the IDLE->PLAY transition SHALL NOT be counted.

Reset
REQ-033 rst_n=0 SHALL clear the table, the counter, note_idx, gate, step_strobe and delta_out to 0, set the state to IDLE, set direction to ascending, and load the LFSR with 16'hACE1, overriding every other input including wr_en.

Structure
REQ-034 Package arp_pkg SHALL hold the pattern codes, the FSM state encoding, LFSR_SEED=16'hACE1 and the LFSR tap mask (x^16+x^14+x^13+x^11+1).
REQ-035 Sub-module arp_lfsr: 16-bit Fibonacci LFSR with advance strobe, synchronous active-low reset to seed.

Verification
REQ-036 Table {38222,45450,51020}, num_notes=3, UP, note_dur=4, gate_len=4, ticks every cycle -> delta_out 38222x4, 45450x4, 51020x4, repeating; step_strobe every 4 ticks.
REQ-037 Same table, UPDOWN -> note_idx sequence 0,1,2,1,0,1,2; DOWN -> 2,1,0,2.
REQ-038 note_dur=4, gate_len=2 -> per step, delta_out is nonzero for 2 samples then 0 for 2; gate matches.
REQ-039 At note_idx=2, set num_notes=2 -> next step idx 0 under UP; num_notes=0 -> IDLE, delta_out=0 on the next cycle.
REQ-040 RANDOM, num_notes=3, 1000 steps -> every idx < 3 and sequence repeatable after reset; assert rst_n=0 mid-step -> all outputs 0 on the next edge and table reads 0.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared types and constants for the arpeggiator sequencer.
package arp_pkg;

  typedef enum logic [1:0] {
    PAT_UP     = 2'd0,
    PAT_DOWN   = 2'd1,
    PAT_UPDOWN = 2'd2,
    PAT_RANDOM = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting form: bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/arp_if.sv
// Control, chord-table write and note output bundle of the sequencer.
interface arp_if #(
  parameter int MAX_NOTES   = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int DUR_WIDTH   = 16
);
  localparam int IDX_W = $clog2(MAX_NOTES);

  logic                   sample_tick;
  logic                   enable;
  logic [1:0]             pattern;
  logic [IDX_W:0]         num_notes;
  logic [DUR_WIDTH-1:0]   note_dur;
  logic [DUR_WIDTH-1:0]   gate_len;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_addr;
  logic [PHASE_WIDTH-1:0] wr_delta;
  logic [PHASE_WIDTH-1:0] delta_out;
  logic [IDX_W-1:0]       note_idx;
  logic                   gate;
  logic                   step_strobe;

  modport master (
    output sample_tick, enable, pattern, num_notes,
    output note_dur, gate_len, wr_en, wr_addr, wr_delta,
    input  delta_out, note_idx, gate, step_strobe
  );

  modport slave (
    input  sample_tick, enable, pattern, num_notes,
    input  note_dur, gate_len, wr_en, wr_addr, wr_delta,
    output delta_out, note_idx, gate, step_strobe
  );

endinterface

// File: rtl/arp_lfsr.sv
// 16-bit Fibonacci LFSR, stepped once per arpeggio step.
import arp_pkg::*;

module arp_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  output logic [7:0] rnd_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (adv_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign rnd_o = lfsr_q[7:0];

endmodule

// File: rtl/arp_sequencer.sv
// Arpeggiator: walks a chord table of DDS phase increments at a
// sample-rate tempo and emits a gated increment for each step.
import arp_pkg::*;

module arp_sequencer #(
  parameter int MAX_NOTES   = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int DUR_WIDTH   = 16
) (
  input logic  clk,
  input logic  rst_n,
  arp_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_NOTES);

  typedef logic [IDX_W-1:0]       idx_t;
  typedef logic [IDX_W:0]         num_t;
  typedef logic [DUR_WIDTH-1:0]   dur_t;
  typedef logic [PHASE_WIDTH-1:0] ph_t;

  localparam idx_t IDX_ONE = idx_t'(1);
  localparam num_t NUM_ONE = num_t'(1);
  localparam dur_t DUR_ONE = dur_t'(1);

  state_e   state_q, state_d;
  dur_t     cnt_q, cnt_d;
  idx_t     idx_q, idx_d;
  logic     dir_q, dir_d;
  pattern_e pat_q, pat_d;
  logic     gate_q, gate_d;
  logic     strb_q;
  ph_t      delta_q;
  ph_t      tbl_q [MAX_NOTES];

  pattern_e   pat;
  num_t       n, n_m1;
  dur_t       last;
  logic       run, start, step;
  logic [7:0] rnd, rmod;
  idx_t       rnd_idx, start_idx, next_idx;
  logic       next_dir, desc;

  assign pat     = pattern_e'(bus.pattern);
  assign n       = bus.num_notes;
  assign n_m1    = n - NUM_ONE;
  assign last    = (bus.note_dur == '0) ? '0 : bus.note_dur - DUR_ONE;
  assign run     = bus.enable && (n != '0);
  assign start   = (state_q == ST_IDLE) && run;
  assign step    = start || ((state_q == ST_PLAY) && run &&
                             bus.sample_tick && (cnt_q >= last));
  assign rmod    = rnd % ((n == '0) ? 8'd1 : 8'(n));
  assign rnd_idx = idx_t'(rmod);

  arp_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (step),
    .rnd_o (rnd)
  );

  always_comb begin
    unique case (pat)
      PAT_DOWN:   start_idx = idx_t'(n_m1);
      PAT_RANDOM: start_idx = rnd_idx;
      default:    start_idx = '0;
    endcase

    // An index left outside a shrunken chord restarts the pattern
    next_idx = start_idx;
    next_dir = 1'b0;
    desc     = (pat_q == PAT_UPDOWN) && dir_q;
    if (pat != PAT_RANDOM && {1'b0, idx_q} < n) begin
      unique case (pat)
        PAT_UP: begin
          next_idx = ({1'b0, idx_q} == n_m1) ? '0 : idx_q + IDX_ONE;
        end
        PAT_DOWN: begin
          next_idx = (idx_q == '0) ? idx_t'(n_m1) : idx_q - IDX_ONE;
        end
        default: begin
          if (n == NUM_ONE) begin
            next_idx = '0;
          end else if (!desc && {1'b0, idx_q} == n_m1) begin
            next_idx = idx_q - IDX_ONE;
            next_dir = 1'b1;
          end else if (desc && idx_q == '0) begin
            next_idx = IDX_ONE;
          end else if (desc) begin
            next_idx = idx_q - IDX_ONE;
            next_dir = 1'b1;
          end else begin
            next_idx = idx_q + IDX_ONE;
          end
        end
      endcase
    end

    state_d = run ? ST_PLAY : ST_IDLE;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    pat_d   = pat_q;
    if (step) begin
      cnt_d = '0;
      pat_d = pat;
      idx_d = start ? start_idx : next_idx;
      dir_d = start ? 1'b0 : next_dir;
    end else if (state_q == ST_PLAY && bus.sample_tick) begin
      cnt_d = cnt_q + DUR_ONE;
    end
    gate_d = run && (cnt_d < bus.gate_len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      pat_q   <= PAT_UP;
      gate_q  <= 1'b0;
      strb_q  <= 1'b0;
      delta_q <= '0;
      for (int i = 0; i < MAX_NOTES; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      pat_q   <= pat_d;
      gate_q  <= gate_d;
      strb_q  <= step;
      delta_q <= gate_d ? tbl_q[idx_d] : '0;
      if (bus.wr_en) begin
        tbl_q[bus.wr_addr] <= bus.wr_delta;
      end
    end
  end

  assign bus.delta_out   = delta_q;
  assign bus.note_idx    = idx_q;
  assign bus.gate        = gate_q;
  assign bus.step_strobe = strb_q;

endmodule

// File: tb/tb_arp_sequencer.sv
// Self-checking bench for arp_sequencer: vector table, directed
// corner sequences and randomized runs against a step-level model.
module tb_arp_sequencer;
  import arp_pkg::*;

  localparam int MN = 8;
  localparam int PW = 32;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arp_if #(.MAX_NOTES(MN), .PHASE_WIDTH(PW), .DUR_WIDTH(DW)) u_if ();

  arp_sequencer #(.MAX_NOTES(MN), .PHASE_WIDTH(PW), .DUR_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the step sequence with plain integers
  longint      m_tbl [MN];
  bit          m_play;
  int          m_cnt, m_idx, m_ph, m_lastpat;
  logic [15:0] m_lfsr;
  longint      e_delta;
  bit          e_gate, e_strb;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  task automatic m_newstep(input bit first);
    int n, p;
    n = int'(u_if.num_notes);
    p = int'(u_if.pattern);
    if (p == 3) begin
      m_idx = int'(m_lfsr & 16'h00FF) % n;
    end else if (first || m_idx >= n) begin
      m_idx = (p == 1) ? n - 1 : 0;
      m_ph  = 0;
    end else if (p == 0) begin
      m_idx = (m_idx + 1) % n;
    end else if (p == 1) begin
      m_idx = (m_idx + n - 1) % n;
    end else if (n == 1) begin
      m_idx = 0;
    end else begin
      if (m_lastpat != 2) m_ph = m_idx;
      m_ph  = (m_ph + 1) % (2 * n - 2);
      m_idx = (m_ph < n) ? m_ph : 2 * n - 2 - m_ph;
    end
    m_lfsr    = lfsr_adv(m_lfsr);
    m_lastpat = p;
  endtask

  task automatic m_cycle();
    int n, last;
    bit run;
    if (!rst_n) begin
      m_play = 0; m_cnt = 0; m_idx = 0; m_ph = 0; m_lastpat = 0;
      m_lfsr = LFSR_SEED;
      for (int i = 0; i < MN; i++) m_tbl[i] = 0;
      e_delta = 0; e_gate = 0; e_strb = 0;
      return;
    end
    n    = int'(u_if.num_notes);
    run  = u_if.enable && n != 0;
    last = (u_if.note_dur == 0) ? 0 : int'(u_if.note_dur) - 1;
    e_strb = 0;
    if (!m_play) begin
      if (run) begin
        m_play = 1; m_cnt = 0; m_newstep(1); e_strb = 1;
      end
    end else if (!run) begin
      m_play = 0;
    end else if (u_if.sample_tick) begin
      if (m_cnt >= last) begin
        m_cnt = 0; m_newstep(0); e_strb = 1;
      end else begin
        m_cnt++;
      end
    end
    e_gate  = m_play && (m_cnt < int'(u_if.gate_len));
    e_delta = e_gate ? m_tbl[m_idx] : 0;
    if (u_if.wr_en) m_tbl[int'(u_if.wr_addr)] = longint'(u_if.wr_delta);
  endtask

  task automatic cyc();
    m_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm);
    chk({nm, "_delta"}, longint'(u_if.delta_out), e_delta);
    chk({nm, "_gate"}, longint'(u_if.gate), longint'(e_gate));
    chk({nm, "_strobe"}, longint'(u_if.step_strobe), longint'(e_strb));
    chk({nm, "_idx"}, longint'(u_if.note_idx), longint'(m_idx));
  endtask

  typedef struct {
    bit     en;
    bit     tick;
    int     gl;
    longint e_delta;
    bit     e_gate;
    bit     e_strb;
    int     e_idx;
  } vec_t;

  vec_t   vt [24];
  longint dtab [3] = '{38222, 45450, 51020};
  int     ud_seq [7] = '{0, 1, 2, 1, 0, 1, 2};
  int     dn_seq [4] = '{2, 1, 0, 2};
  int     rexp [1000];
  int     k, s, g;
  logic [15:0] ls;

  initial begin
    for (int i = 0; i < 24; i++) begin
      k = i % 4;
      s = (i / 4) % 3;
      g = (i < 12) ? 4 : 2;
      vt[i].en      = 1;
      vt[i].tick    = 1;
      vt[i].gl      = g;
      vt[i].e_gate  = (k < g);
      vt[i].e_delta = (k < g) ? dtab[s] : 0;
      vt[i].e_strb  = (k == 0);
      vt[i].e_idx   = s;
    end
    ls = LFSR_SEED;
    for (int i = 0; i < 1000; i++) begin
      rexp[i] = int'(ls[7:0]) % 3;
      ls = lfsr_adv(ls);
    end

    u_if.sample_tick = 0; u_if.enable = 0; u_if.pattern = 2'd0;
    u_if.num_notes = '0; u_if.note_dur = '0; u_if.gate_len = '0;
    u_if.wr_en = 0; u_if.wr_addr = '0; u_if.wr_delta = '0;

    rst_n = 0;
    cyc(); cyc();
    chk("rst_delta", longint'(u_if.delta_out), 0);
    chk("rst_gate", longint'(u_if.gate), 0);
    chk("rst_strobe", longint'(u_if.step_strobe), 0);
    chk("rst_idx", longint'(u_if.note_idx), 0);
    rst_n = 1;

    for (int i = 0; i < 3; i++) begin
      u_if.wr_en = 1; u_if.wr_addr = 3'(i); u_if.wr_delta = 32'(dtab[i]);
      cyc();
    end
    u_if.wr_en = 0;

    // UP, note_dur 4, gate 4 then 2, tick every cycle
    u_if.pattern = 2'd0; u_if.num_notes = 4'd3; u_if.note_dur = 16'd4;
    for (int i = 0; i < 24; i++) begin
      u_if.enable = vt[i].en;
      u_if.sample_tick = vt[i].tick;
      u_if.gate_len = 16'(vt[i].gl);
      cyc();
      chk($sformatf("vec%0d_delta", i), longint'(u_if.delta_out), vt[i].e_delta);
      chk($sformatf("vec%0d_gate", i), longint'(u_if.gate), longint'(vt[i].e_gate));
      chk($sformatf("vec%0d_strobe", i), longint'(u_if.step_strobe), longint'(vt[i].e_strb));
      chk($sformatf("vec%0d_idx", i), longint'(u_if.note_idx), longint'(vt[i].e_idx));
    end

    u_if.enable = 0;
    cyc();
    chk("idle_delta", longint'(u_if.delta_out), 0);
    chk("idle_gate", longint'(u_if.gate), 0);
    u_if.pattern = 2'd2; u_if.note_dur = 16'd1; u_if.gate_len = 16'd1;
    u_if.enable = 1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("updown%0d", i), longint'(u_if.note_idx), longint'(ud_seq[i]));
    end

    u_if.enable = 0;
    cyc();
    u_if.pattern = 2'd1; u_if.enable = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("down%0d", i), longint'(u_if.note_idx), longint'(dn_seq[i]));
    end

    u_if.enable = 0;
    cyc();
    u_if.pattern = 2'd0; u_if.enable = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (u_if.note_idx == 3'd2) break;
    end
    chk("reach_idx2", longint'(u_if.note_idx), 2);
    u_if.num_notes = 4'd2;
    cyc();
    chk("shrink_restart", longint'(u_if.note_idx), 0);
    u_if.num_notes = 4'd0;
    cyc();
    chk("zero_notes_delta", longint'(u_if.delta_out), 0);
    chk("zero_notes_gate", longint'(u_if.gate), 0);

    // Write to the sounding entry while the counter is frozen
    u_if.num_notes = 4'd3; u_if.note_dur = 16'd8; u_if.gate_len = 16'd8;
    u_if.sample_tick = 0;
    cyc();
    chk("hold_delta0", longint'(u_if.delta_out), dtab[0]);
    u_if.wr_en = 1; u_if.wr_addr = 3'd0; u_if.wr_delta = 32'd12345;
    cyc();
    chk("wr_same_cycle", longint'(u_if.delta_out), dtab[0]);
    chk("hold_strobe", longint'(u_if.step_strobe), 0);
    u_if.wr_en = 0;
    cyc();
    chk("wr_next_cycle", longint'(u_if.delta_out), 12345);
    chk("hold_idx", longint'(u_if.note_idx), 0);

    u_if.enable = 0; rst_n = 0;
    cyc();
    rst_n = 1;
    u_if.pattern = 2'd3; u_if.num_notes = 4'd3; u_if.note_dur = 16'd1;
    u_if.gate_len = 16'd1; u_if.sample_tick = 1; u_if.enable = 1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      chk("rand_range", longint'(u_if.note_idx < 3'd3), 1);
      chk($sformatf("rand_seq%0d", i), longint'(u_if.note_idx), longint'(rexp[i]));
    end

    u_if.note_dur = 16'd4;
    cyc(); cyc();
    rst_n = 0;
    u_if.wr_en = 1; u_if.wr_addr = 3'd1; u_if.wr_delta = 32'd999;
    cyc();
    chk("midrst_delta", longint'(u_if.delta_out), 0);
    chk("midrst_gate", longint'(u_if.gate), 0);
    chk("midrst_strobe", longint'(u_if.step_strobe), 0);
    chk("midrst_idx", longint'(u_if.note_idx), 0);
    rst_n = 1; u_if.wr_en = 0; u_if.note_dur = 16'd1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk($sformatf("rand_rep%0d", i), longint'(u_if.note_idx), longint'(rexp[i]));
    end

    u_if.enable = 0;
    cyc();
    u_if.pattern = 2'd0; u_if.gate_len = 16'd4; u_if.enable = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("clr_tbl_gate%0d", i), longint'(u_if.gate), 1);
      chk($sformatf("clr_tbl_idx%0d", i), longint'(u_if.note_idx), longint'(i));
      chk($sformatf("clr_tbl_delta%0d", i), longint'(u_if.delta_out), 0);
    end

    // Randomized epochs against the model
    u_if.enable = 0; rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < MN; i++) begin
      u_if.wr_en = 1; u_if.wr_addr = 3'(i);
      u_if.wr_delta = 32'($urandom_range(1, 32'h7fff_ffff));
      cyc();
    end
    u_if.wr_en = 0;
    for (int e = 0; e < 40; e++) begin
      u_if.enable = 0;
      u_if.num_notes = 4'($urandom_range(0, MN));
      u_if.pattern = 2'($urandom_range(0, 3));
      u_if.note_dur = 16'($urandom_range(0, 5));
      u_if.gate_len = 16'($urandom_range(0, 6));
      cyc();
      chk_all("rnd_idle");
      u_if.enable = 1;
      for (int c = 0; c < 60; c++) begin
        u_if.sample_tick = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) u_if.pattern = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) u_if.gate_len = 16'($urandom_range(0, 6));
        u_if.enable = ($urandom_range(0, 63) != 0);
        u_if.wr_en = ($urandom_range(0, 7) == 0);
        u_if.wr_addr = 3'($urandom_range(0, MN - 1));
        u_if.wr_delta = 32'($urandom);
        cyc();
        chk_all("rnd");
      end
      u_if.wr_en = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
